gray_step_tracker: RTL

- Downstream consumer of the gray counter stage. Registers each N-bit gray sample and decodes it to binary.
- Checks that consecutive samples are legal single-step moves, in either direction, including wrap-around.
- Maintains a signed position accumulator and a saturating error counter.
- Sits between the gray source and any logic that needs a validated binary count or position.

---
 rtl/gray_step_tracker.sv | 124 ++++++++++++
 1 files changed

// File: rtl/gray_step_tracker.sv
// Gray sample tracker: decodes to binary, validates +/-1 steps, keeps position and error count.
// Optional macro GRAY_STEP_STALL_ERR_EN makes a repeated sample in LOCKED an error.
module gray_step_tracker #(
  parameter int N     = 3,
  parameter int POS_W = 16,
  parameter int ERR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [N-1:0]            gray_in,
  output logic                    out_valid,
  output logic [N-1:0]            bin_out,
  output logic                    step_up,
  output logic                    step_dn,
  output logic                    step_err,
  output logic                    locked,
  output logic signed [POS_W-1:0] position,
  output logic [ERR_W-1:0]        err_count
);

`ifdef GRAY_STEP_STALL_ERR_EN
  localparam bit STALL_ERR = 1'b1;
`else
  localparam bit STALL_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED,
    RESYNC
  } state_t;

  state_t            state_q;
  logic              out_valid_q;
  logic [N-1:0]      bin_q;
  logic              step_up_q;
  logic              step_dn_q;
  logic              step_err_q;
  logic              locked_q;
  logic [POS_W-1:0]  pos_q;
  logic [ERR_W-1:0]  err_q;

  logic [N-1:0]      bin_d;
  logic [N-1:0]      diff_d;
  logic              up_d;
  logic              dn_d;
  logic              same_d;
  logic              bad_d;

  // Each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    bin_d = '0;
    for (int i = 0; i < N; i++) begin
      bin_d[i] = ^(gray_in >> i);
    end
  end

  always_comb begin
    diff_d = bin_d - bin_q;
    up_d   = (diff_d == N'(1));
    dn_d   = (diff_d == {N{1'b1}});
    same_d = (diff_d == '0);
    bad_d  = !(up_d || dn_d) && (!same_d || STALL_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      step_up_q   <= 1'b0;
      step_dn_q   <= 1'b0;
      step_err_q  <= 1'b0;
      locked_q    <= 1'b0;
      pos_q       <= '0;
      err_q       <= '0;
    end else begin
      out_valid_q <= in_valid;
      step_up_q   <= 1'b0;
      step_dn_q   <= 1'b0;
      step_err_q  <= 1'b0;
      if (in_valid) begin
        bin_q <= bin_d;
        unique case (state_q)
          LOCKED: begin
            if (bad_d) begin
              step_err_q <= 1'b1;
              locked_q   <= 1'b0;
              state_q    <= RESYNC;
              if (err_q != {ERR_W{1'b1}}) begin
                err_q <= err_q + ERR_W'(1);
              end
            end else if (up_d) begin
              step_up_q <= 1'b1;
              pos_q     <= pos_q + POS_W'(1);
            end else if (dn_d) begin
              step_dn_q <= 1'b1;
              pos_q     <= pos_q - POS_W'(1);
            end
          end
          UNLOCKED, RESYNC: begin
            locked_q <= 1'b1;
            state_q  <= LOCKED;
          end
          default: begin
            locked_q <= 1'b0;
            state_q  <= UNLOCKED;
          end
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign step_up   = step_up_q;
  assign step_dn   = step_dn_q;
  assign step_err  = step_err_q;
  assign locked    = locked_q;
  assign position  = pos_q;
  assign err_count = err_q;

endmodule
